// File: rtl/serial_adder_fsm.sv
// Bit-serial add/subtract unit: one full-adder cell and a carry flop, LSB-first, WIDTH cycles per operation.
// Optional signed-overflow output is enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder_fsm #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] result;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             bit_sum;
  logic             carry_next;
  logic             last_bit;

  // The single full-adder cell shared by every bit position.
  assign bit_sum    = op_a[0] ^ op_b[0] ^ carry;
  assign carry_next = (op_a[0] & op_b[0]) | (op_a[0] & carry) | (op_b[0] & carry);
  assign last_bit   = (cnt == LAST_BIT);

  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // NOTE: the shift registers are reset too, so an aborted operation leaves no residue.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a      <= '0;
      op_b      <= '0;
      result    <= '0;
      cnt       <= '0;
      carry     <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      overflow  <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            // Subtraction is a + ~b + ~borrow_in, so carry_out=1 means no borrow.
            op_a  <= a;
            op_b  <= sub ? ~b : b;
            carry <= sub ? ~carry_in : carry_in;
            cnt   <= '0;
          end
        end
        RUN: begin
          op_a   <= {1'b0, op_a[WIDTH-1:1]};
          op_b   <= {1'b0, op_b[WIDTH-1:1]};
          result <= {bit_sum, result[WIDTH-1:1]};
          carry  <= carry_next;
          cnt    <= cnt + 1'b1;
          if (last_bit) begin
            sum       <= {bit_sum, result[WIDTH-1:1]};
            carry_out <= carry_next;
`ifdef SERIAL_ADDER_OVF_EN
            // carry currently holds the carry into the MSB cell.
            overflow  <= carry ^ carry_next;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule
